// File: rtl/qr_givens_scheduler_pkg.sv
// Shared widths, defaults and FSM encoding for the Givens row-pair scheduler.
`timescale 1ns/1ps
package qr_givens_scheduler_pkg;
  localparam int WL          = 16;
  localparam int N_DEF       = 8;
  localparam int ROT_LAT_DEF = 1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;
endpackage

// File: rtl/qr_givens_scheduler_lane.sv
// Combinational lane shifter: moves a WL*N row by shift_i lanes, zero filling vacated lanes.
`timescale 1ns/1ps
module qr_lane_shifter
  import qr_givens_scheduler_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter bit UP = 1'b0,
  parameter int CW = $clog2(N)
) (
  input  logic [WL*N-1:0] row_i,
  input  logic [CW-1:0]   shift_i,
  output logic [WL*N-1:0] row_o
);
  // UP: lane j takes lane j-c (write-back); otherwise lane j takes lane j+c (issue).
  if (UP) begin : g_up
    assign row_o = row_i << (WL * shift_i);
  end else begin : g_down
    assign row_o = row_i >> (WL * shift_i);
  end
endmodule

// File: rtl/qr_givens_scheduler.sv
// Buffers H and y, issues Givens row pairs in annihilation order, writes results back, streams R and Q^T y.
`timescale 1ns/1ps
module qr_givens_scheduler
  import qr_givens_scheduler_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int ROT_LAT = ROT_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WL*N-1:0] in_row,
  input  logic [WL-1:0]   in_y,
  output logic [WL*N-1:0] rot_hx,
  output logic [WL*N-1:0] rot_hy,
  output logic [WL-1:0]   rot_yx,
  output logic [WL-1:0]   rot_yy,
  output logic            rot_issue,
  input  logic [WL*N-1:0] rot_hx_ret,
  input  logic [WL*N-1:0] rot_hy_ret,
  input  logic [WL-1:0]   rot_yx_ret,
  input  logic [WL-1:0]   rot_yy_ret,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WL*N-1:0] out_row,
  output logic [WL-1:0]   out_y,
  output logic            busy
);
  localparam int CW = $clog2(N);
  localparam int LW = $clog2(ROT_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] LAST_PIVOT = CW'(N - 2);

  state_e          state_q, state_d;
  logic [CW-1:0]   k_q, k_d;
  logic [CW-1:0]   c_q, c_d;
  logic [CW-1:0]   r_q, r_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [WL*N-1:0] h_q [N];
  logic [WL-1:0]   y_q [N];
  logic [WL*N-1:0] rot_hx_q, rot_hy_q;
  logic [WL-1:0]   rot_yx_q, rot_yy_q;

  logic            load_we, wb_we;
  logic [WL*N-1:0] hx_dn, hy_dn, wb_x, wb_y;

  qr_lane_shifter #(.N(N), .UP(1'b0)) u_shift_hx (.row_i(h_q[c_q]), .shift_i(c_q), .row_o(hx_dn));
  qr_lane_shifter #(.N(N), .UP(1'b0)) u_shift_hy (.row_i(h_q[r_q]), .shift_i(c_q), .row_o(hy_dn));
  qr_lane_shifter #(.N(N), .UP(1'b1)) u_wb_x     (.row_i(rot_hx_ret), .shift_i(c_q), .row_o(wb_x));
  qr_lane_shifter #(.N(N), .UP(1'b1)) u_wb_y     (.row_i(rot_hy_ret), .shift_i(c_q), .row_o(wb_y));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    c_d       = c_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rot_issue = 1'b0;
    load_we   = 1'b0;
    wb_we     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_we = 1'b1;
          if (k_q == LAST) begin
            k_d     = '0;
            c_d     = '0;
            r_d     = CW'(1);
            state_d = ST_ISSUE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        rot_issue = 1'b1;
        cnt_d     = LW'(ROT_LAT);
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // The counter is about to reach zero: the returned rows are valid now.
        if (cnt_q == LW'(1)) begin
          wb_we = 1'b1;
          if (c_q == LAST_PIVOT && r_q == LAST) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ISSUE;
            if (r_q == LAST) begin
              c_d = c_q + 1'b1;
              r_d = c_q + CW'(2);
            end else begin
              r_d = r_q + 1'b1;
            end
          end
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (k_q == LAST) begin
            k_d     = '0;
            state_d = ST_LOAD;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      k_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  // Rows c and r never alias (r > c), so both write-back ports may fire together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        h_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      if (load_we) begin
        h_q[k_q] <= in_row;
        y_q[k_q] <= in_y;
      end
      if (wb_we) begin
        h_q[c_q] <= wb_x;
        h_q[r_q] <= wb_y;
        y_q[c_q] <= rot_yx_ret;
        y_q[r_q] <= rot_yy_ret;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_hx_q <= '0;
      rot_hy_q <= '0;
      rot_yx_q <= '0;
      rot_yy_q <= '0;
    end else if (rot_issue) begin
      rot_hx_q <= hx_dn;
      rot_hy_q <= hy_dn;
      rot_yx_q <= y_q[c_q];
      rot_yy_q <= y_q[r_q];
    end
  end

  // Outside ISSUE the rotation interface replays the last pair.
  assign rot_hx  = rot_issue ? hx_dn    : rot_hx_q;
  assign rot_hy  = rot_issue ? hy_dn    : rot_hy_q;
  assign rot_yx  = rot_issue ? y_q[c_q] : rot_yx_q;
  assign rot_yy  = rot_issue ? y_q[r_q] : rot_yy_q;

  assign out_row = h_q[k_q];
  assign out_y   = y_q[k_q];
  assign busy    = (state_q != ST_LOAD);
endmodule

// File: tb/tb_qr_givens_scheduler.sv
// Directed bench for qr_givens_scheduler with a one-register rotation-stage stub.
`timescale 1ns/1ps
module tb_qr_givens_scheduler;
  import qr_givens_scheduler_pkg::*;
  localparam int N  = 8;
  localparam int RW = WL * N;
  localparam int NR = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] in_row = '0;
  logic [WL-1:0] in_y = '0;
  logic [RW-1:0] rot_hx, rot_hy;
  logic [WL-1:0] rot_yx, rot_yy;
  logic          rot_issue;
  logic [RW-1:0] rot_hx_ret = '0, rot_hy_ret = '0;
  logic [WL-1:0] rot_yx_ret = '0, rot_yy_ret = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RW-1:0] out_row;
  logic [WL-1:0] out_y;
  logic          busy;

  qr_givens_scheduler #(.N(N), .ROT_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .in_y(in_y),
    .rot_hx(rot_hx), .rot_hy(rot_hy), .rot_yx(rot_yx), .rot_yy(rot_yy), .rot_issue(rot_issue),
    .rot_hx_ret(rot_hx_ret), .rot_hy_ret(rot_hy_ret), .rot_yx_ret(rot_yx_ret), .rot_yy_ret(rot_yy_ret),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_y(out_y), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Rotation-stage stub: one register, returns driven values plus inc per lane.
  logic [WL-1:0] inc = '0;
  always @(posedge clk) begin
    for (int j = 0; j < N; j++) begin
      rot_hx_ret[WL*j +: WL] <= rot_hx[WL*j +: WL] + inc;
      rot_hy_ret[WL*j +: WL] <= rot_hy[WL*j +: WL] + inc;
    end
    rot_yx_ret <= rot_yx + inc;
    rot_yy_ret <= rot_yy + inc;
  end

  logic [RW-1:0] rec_hx [NR];
  logic [RW-1:0] rec_hy [NR];
  logic [WL-1:0] rec_yx [NR];
  logic [WL-1:0] rec_yy [NR];
  int            rec_cyc [NR];
  int            n_iss = 0;
  always @(negedge clk) begin
    if (rot_issue) begin
      if (n_iss < NR) begin
        rec_hx[n_iss]  = rot_hx;
        rec_hy[n_iss]  = rot_hy;
        rec_yx[n_iss]  = rot_yx;
        rec_yy[n_iss]  = rot_yy;
        rec_cyc[n_iss] = cyc;
      end
      n_iss = n_iss + 1;
    end
  end

  int checks = 0;
  int failures = 0;
  logic [RW-1:0] m_row [N];
  logic [WL-1:0] m_y [N];
  logic [RW-1:0] got_row [N];
  logic [WL-1:0] got_y [N];
  int n_got, last_beat, first_out;

  function automatic logic [WL-1:0] lane(input logic [RW-1:0] row, input int j);
    return row[WL*j +: WL];
  endfunction

  task automatic set_identity();
    for (int i = 0; i < N; i++) begin
      m_row[i] = '0;
      m_row[i][WL*i +: WL] = WL'(1);
      m_y[i] = WL'(i + 1);
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) m_row[i][WL*j +: WL] = WL'(16 * i + j + 1);
      m_y[i] = WL'(16'h40 + i);
    end
  endtask

  task automatic load_matrix();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_row   = m_row[k];
      in_y     = m_y[k];
      @(posedge clk);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    last_beat = cyc;
  endtask

  task automatic collect();
    int guard;
    guard = 0;
    n_got = 0;
    first_out = -1;
    out_ready = 1'b1;
    while (n_got < N && guard < 400) begin
      @(negedge clk);
      guard++;
      if (out_valid) begin
        if (first_out < 0) first_out = cyc;
        got_row[n_got] = out_row;
        got_y[n_got]   = out_y;
        n_got++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (rot_issue !== 1'b0) begin failures++; $display("FAIL reset_rot_issue got=%b exp=0", rot_issue); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_row !== '0) begin failures++; $display("FAIL reset_buffer got=%h exp=0", out_row); end
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    int base;
    set_identity();
    inc = '0;
    base = n_iss;
    load_matrix();
    collect();
    checks++; if (n_got !== N) begin failures++; $display("FAIL ident_beats got=%0d exp=%0d", n_got, N); end
    checks++; if (n_iss - base !== 28) begin failures++; $display("FAIL ident_issues got=%0d exp=28", n_iss - base); end
    checks++; if (first_out - last_beat !== 56) begin failures++; $display("FAIL ident_latency got=%0d exp=56", first_out - last_beat); end
    if (n_iss - base == 28) begin
      for (int i = 1; i < 28; i++) begin
        checks++;
        if (rec_cyc[base+i] - rec_cyc[base+i-1] !== 2) begin
          failures++; $display("FAIL ident_spacing[%0d] got=%0d exp=2", i, rec_cyc[base+i] - rec_cyc[base+i-1]);
        end
      end
    end
    for (int k = 0; k < n_got; k++) begin
      checks++; if (got_row[k] !== m_row[k]) begin failures++; $display("FAIL ident_row[%0d] got=%h exp=%h", k, got_row[k], m_row[k]); end
      checks++; if (got_y[k] !== WL'(k + 1)) begin failures++; $display("FAIL ident_y[%0d] got=%0d exp=%0d", k, got_y[k], k + 1); end
    end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ident_back_to_load got=%b%b exp=10", in_ready, busy); end
  endtask

  task automatic test_issue_order();
    int base, idx;
    set_ramp();
    inc = '0;
    base = n_iss;
    load_matrix();
    collect();
    checks++; if (n_iss - base !== 28) begin failures++; $display("FAIL order_issues got=%0d exp=28", n_iss - base); end
    if (n_iss - base == 28) begin
      idx = base;
      for (int c = 0; c < N - 1; c++) begin
        for (int r = c + 1; r < N; r++) begin
          checks++;
          if (rec_yx[idx] !== m_y[c] || rec_yy[idx] !== m_y[r]) begin
            failures++; $display("FAIL order_pair[%0d] got=%h/%h exp=%h/%h", idx - base, rec_yx[idx], rec_yy[idx], m_y[c], m_y[r]);
          end
          if (c == 3) begin
            checks++; if (lane(rec_hx[idx], 0) !== WL'(52)) begin failures++; $display("FAIL order_hx_lane0 r=%0d got=%0d exp=52", r, lane(rec_hx[idx], 0)); end
            checks++; if (lane(rec_hx[idx], 1) !== WL'(53)) begin failures++; $display("FAIL order_hx_lane1 r=%0d got=%0d exp=53", r, lane(rec_hx[idx], 1)); end
            checks++; if (lane(rec_hy[idx], 0) !== WL'(16 * r + 4)) begin failures++; $display("FAIL order_hy_lane0 r=%0d got=%0d exp=%0d", r, lane(rec_hy[idx], 0), 16 * r + 4); end
            for (int j = 5; j < N; j++) begin
              checks++;
              if (lane(rec_hx[idx], j) !== '0 || lane(rec_hy[idx], j) !== '0) begin
                failures++; $display("FAIL order_zero_fill r=%0d lane=%0d got=%0d/%0d exp=0", r, j, lane(rec_hx[idx], j), lane(rec_hy[idx], j));
              end
            end
          end
          idx++;
        end
      end
    end
  endtask

  task automatic test_writeback();
    logic [WL-1:0] e;
    for (int i = 0; i < N; i++) begin
      m_row[i] = '0;
      m_y[i]   = '0;
    end
    inc = WL'(1);
    load_matrix();
    collect();
    inc = '0;
    checks++; if (n_got !== N) begin failures++; $display("FAIL wb_beats got=%0d exp=%0d", n_got, N); end
    // Row i is last rewritten with pivot min(i,6): lanes left of that are 0, the rest saw 7 rotations.
    for (int i = 0; i < n_got; i++) begin
      for (int j = 0; j < N; j++) begin
        e = (j < ((i < N - 2) ? i : N - 2)) ? WL'(0) : WL'(7);
        checks++;
        if (lane(got_row[i], j) !== e) begin failures++; $display("FAIL wb_R[%0d][%0d] got=%0d exp=%0d", i, j, lane(got_row[i], j), e); end
      end
      checks++; if (got_y[i] !== WL'(7)) begin failures++; $display("FAIL wb_y[%0d] got=%0d exp=7", i, got_y[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] hold_row;
    logic [WL-1:0] hold_y;
    int k, guard;
    bit stalled;
    set_identity();
    load_matrix();
    k = 0; guard = 0; stalled = 1'b0;
    out_ready = 1'b1;
    while (k < N && guard < 400) begin
      @(negedge clk);
      guard++;
      if (out_valid) begin
        if (k == 3 && !stalled) begin
          out_ready = 1'b0;
          hold_row  = out_row;
          hold_y    = out_y;
          repeat (5) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_row !== hold_row || out_y !== hold_y) begin
              failures++; $display("FAIL bp_hold got=%b/%h/%0d exp=1/%h/%0d", out_valid, out_row, out_y, hold_row, hold_y);
            end
          end
          stalled   = 1'b1;
          out_ready = 1'b1;
          got_row[k] = hold_row;
          got_y[k]   = hold_y;
        end else begin
          got_row[k] = out_row;
          got_y[k]   = out_y;
        end
        k++;
      end
    end
    checks++; if (k !== N) begin failures++; $display("FAIL bp_beats got=%0d exp=%0d", k, N); end
    for (int i = 0; i < k; i++) begin
      checks++;
      if (got_row[i] !== m_row[i] || got_y[i] !== m_y[i]) begin
        failures++; $display("FAIL bp_beat[%0d] got=%h/%0d exp=%h/%0d", i, got_row[i], got_y[i], m_row[i], m_y[i]);
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra_beat got=%b exp=0", out_valid); end
  endtask

  task automatic test_ignore_input();
    set_ramp();
    load_matrix();
    in_valid = 1'b1;
    in_row   = '1;
    in_y     = '1;
    repeat (55) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ign_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
    end
    collect();
    checks++; if (n_got !== N) begin failures++; $display("FAIL ign_beats got=%0d exp=%0d", n_got, N); end
    // Loopback leaves rows intact except lanes left of the last pivot that touched them.
    for (int i = 0; i < n_got; i++) begin
      for (int j = 0; j < N; j++) begin
        checks++;
        if (lane(got_row[i], j) !== ((j < ((i < N - 2) ? i : N - 2)) ? WL'(0) : lane(m_row[i], j))) begin
          failures++; $display("FAIL ign_R[%0d][%0d] got=%0d", i, j, lane(got_row[i], j));
        end
      end
      checks++; if (got_y[i] !== m_y[i]) begin failures++; $display("FAIL ign_y[%0d] got=%0h exp=%0h", i, got_y[i], m_y[i]); end
    end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ign_reopen got=%b exp=1", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int base, guard;
    set_ramp();
    base = n_iss;
    load_matrix();
    guard = 0;
    while (n_iss < base + 16 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    checks++; if (n_iss < base + 16) begin failures++; $display("FAIL rst_reach_pair got=%0d exp=16", n_iss - base); end
    checks++;
    if (rec_yx[base+15] !== m_y[2] || rec_yy[base+15] !== m_y[5]) begin
      failures++; $display("FAIL rst_pair_2_5 got=%h/%h exp=%h/%h", rec_yx[base+15], rec_yy[base+15], m_y[2], m_y[5]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_out_valid got=%b exp=0", out_valid); end
    checks++; if (rot_issue !== 1'b0) begin failures++; $display("FAIL rst_async_rot_issue got=%b exp=0", rot_issue); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    set_identity();
    load_matrix();
    collect();
    checks++; if (n_got !== N) begin failures++; $display("FAIL rst_reload_beats got=%0d exp=%0d", n_got, N); end
    for (int k = 0; k < n_got; k++) begin
      checks++;
      if (got_row[k] !== m_row[k] || got_y[k] !== WL'(k + 1)) begin
        failures++; $display("FAIL rst_reload[%0d] got=%h/%0d exp=%h/%0d", k, got_row[k], got_y[k], m_row[k], k + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_issue_order();
    test_writeback();
    test_backpressure();
    test_ignore_input();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
